// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-side and decode-side handshakes of the fetch stage, plus the branch redirect.
interface fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  logic        redirect_i;
  logic [31:0] redirect_target_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus8_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_target_i,
    output instr_valid_o, instr_o, pc_o, pc_plus8_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_target_i,
    input  instr_valid_o, instr_o, pc_o, pc_plus8_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// In-order instruction buffer; flush empties it and wins over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full buffer still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, credit-limits memory requests, drops flushed responses.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [CW:0]   in_use;

  logic          accept;
  logic          resp_keep;
  logic          resp_drop;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bypass_avail;
  logic          bypass_take;

  fetch_entry_t  head;
  fetch_entry_t  resp_entry;
  fetch_entry_t  last_entry;
  fetch_entry_t  out_entry;

  // Dropped requests still hold a credit until their response comes back.
  assign in_use          = {1'b0, occupancy} + {1'b0, outstanding};
  assign bus.imem_req_o  = !rst_i && (in_use < CREDITS);
  assign bus.imem_addr_o = fetch_pc;

  assign accept     = bus.imem_req_o && bus.imem_gnt_i;
  assign resp_drop  = bus.imem_rvalid_i && (drop_cnt != '0);
  assign resp_keep  = bus.imem_rvalid_i && (drop_cnt == '0);
  assign resp_entry = '{pc: resp_pc, instr: bus.imem_rdata_i};

`ifdef FETCH_BYPASS_EN
  assign bypass_avail = fifo_empty && resp_keep;
`else
  assign bypass_avail = 1'b0;
`endif
  assign bypass_take = bypass_avail && bus.instr_ready_i;

  assign pop      = bus.instr_ready_i && !fifo_empty;
  assign push_req = resp_keep && !bypass_take;
  assign push     = push_req && (!fifo_full || pop);

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (bus.redirect_i),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  always_comb begin
    outstanding_nxt = outstanding;
    if (accept && !bus.imem_rvalid_i) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!accept && bus.imem_rvalid_i) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  // With the buffer empty, decode sees the last consumed entry (or the bypassed response).
  always_comb begin
    out_entry = last_entry;
    if (!fifo_empty) begin
      out_entry = head;
    end else if (bypass_avail) begin
      out_entry = resp_entry;
    end
  end

  assign bus.instr_valid_o = !fifo_empty || bypass_avail;
  assign bus.instr_o       = out_entry.instr;
  assign bus.pc_o          = out_entry.pc;
  assign bus.pc_plus8_o    = out_entry.pc + PC_READ_OFFSET;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_entry  <= '{pc: RESET_PC, instr: 32'h0};
    end else begin
      outstanding <= outstanding_nxt;
      if (pop || bypass_take) begin
        last_entry <= out_entry;
      end
      // Everything still in flight after this cycle belongs to the old path.
      if (bus.redirect_i) begin
        fetch_pc <= word_align(bus.redirect_target_i);
        resp_pc  <= word_align(bus.redirect_target_i);
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (resp_keep) begin
          resp_pc <= resp_pc + PC_STEP;
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and a wrap-around reset PC)
// behind a bench-side in-order memory with adjustable latency.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .bus   (bus0.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .bus   (bus1.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  pend_t       pend0[$];
  pend_t       pend1[$];
  logic [63:0] dq0[$];
  logic [63:0] dq1[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hE3A0_0001 + (a >> 2);
  endfunction

  // The buffer must never be asked to take a response it has no room for.
  always @(negedge clk) begin
    if (!rst0) begin
      overflow_chk: assert (!(dut0.push_req && dut0.fifo_full && !dut0.pop)) else begin
        failures++;
        $display("[TB] FAIL fifo_overflow actual=push_into_full expected=no_push_into_full");
      end
    end
  end

  // One clock: record handshakes before the edge, then play the memory after it.
  task automatic tick();
    logic        acc0;
    logic        acc1;
    logic [31:0] a0;
    logic [31:0] a1;
    #1;
    acc0 = bus0.imem_req_o && bus0.imem_gnt_i;
    acc1 = bus1.imem_req_o && bus1.imem_gnt_i;
    a0   = bus0.imem_addr_o;
    a1   = bus1.imem_addr_o;
    if (!rst0 && bus0.instr_valid_o && bus0.instr_ready_i) dq0.push_back({bus0.pc_o, bus0.instr_o});
    if (!rst1 && bus1.instr_valid_o && bus1.instr_ready_i) dq1.push_back({bus1.pc_o, bus1.instr_o});
    if (acc0) acc_log.push_back(a0);
    @(posedge clk);
    #1;
    cyc++;
    if (rst0) pend0.delete();
    else if (acc0) pend0.push_back('{a0, cyc - 1 + lat});
    if (rst1) pend1.delete();
    else if (acc1) pend1.push_back('{a1, cyc});
    if (pend0.size() > 0 && pend0[0].due <= cyc) begin
      bus0.imem_rvalid_i = 1'b1;
      bus0.imem_rdata_i  = word_of(pend0[0].addr);
      void'(pend0.pop_front());
    end else begin
      bus0.imem_rvalid_i = 1'b0;
      bus0.imem_rdata_i  = 32'hDEAD_BEEF;
    end
    if (pend1.size() > 0 && pend1[0].due <= cyc) begin
      bus1.imem_rvalid_i = 1'b1;
      bus1.imem_rdata_i  = word_of(pend1[0].addr);
      void'(pend1.pop_front());
    end else begin
      bus1.imem_rvalid_i = 1'b0;
      bus1.imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.imem_gnt_i = 1'b0; bus0.imem_rvalid_i = 1'b0; bus0.imem_rdata_i = 32'h0;
    bus0.redirect_i = 1'b0; bus0.redirect_target_i = 32'h0; bus0.instr_ready_i = 1'b0;
    bus1.imem_gnt_i = 1'b0; bus1.imem_rvalid_i = 1'b0; bus1.imem_rdata_i = 32'h0;
    bus1.redirect_i = 1'b0; bus1.redirect_target_i = 32'h0; bus1.instr_ready_i = 1'b0;
    tick();
    tick();
    checks++;
    if (bus0.imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req actual=%0b expected=0", bus0.imem_req_o); end
    checks++;
    if (bus0.instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%0b expected=0", bus0.instr_valid_o); end
    checks++;
    if (bus0.instr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr actual=%h expected=00000000", bus0.instr_o); end
    checks++;
    if (bus0.pc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc actual=%h expected=00000000", bus0.pc_o); end
    checks++;
    if (bus0.pc_plus8_o !== 32'h8) begin failures++; $display("[TB] FAIL reset_pc_plus8 actual=%h expected=00000008", bus0.pc_plus8_o); end
    checks++;
    if (bus1.pc_o !== 32'hFFFF_FFF8) begin failures++; $display("[TB] FAIL reset_pc_wrapdut actual=%h expected=fffffff8", bus1.pc_o); end
    checks++;
    if (bus1.pc_plus8_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc_plus8_wrap actual=%h expected=00000000", bus1.pc_plus8_o); end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    rst0 = 1'b0;
    bus0.imem_gnt_i    = 1'b1;
    bus0.instr_ready_i = 1'b1;
    exp_pc0 = 32'h0;
    acc_log.delete();
    #1;
    checks++;
    if (bus0.imem_req_o !== 1'b1 || bus0.imem_addr_o !== 32'h0) begin
      failures++; $display("[TB] FAIL basic_first_req actual=req%0b@%h expected=req1@00000000", bus0.imem_req_o, bus0.imem_addr_o);
    end
    checks++;
    if (bus0.instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_c0 actual=%0b expected=0", bus0.instr_valid_o); end
    tick();
    checks++;
`ifdef FETCH_BYPASS_EN
    if (bus0.instr_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid_c1 actual=%0b expected=1", bus0.instr_valid_o); end
`else
    if (bus0.instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_c1 actual=%0b expected=0", bus0.instr_valid_o); end
    tick();
`endif
    checks++;
    if (bus0.instr_valid_o !== 1'b1 || bus0.pc_o !== 32'h0 || bus0.pc_plus8_o !== 32'h8 || bus0.instr_o !== 32'hE3A0_0001) begin
      failures++;
      $display("[TB] FAIL basic_first_instr actual=v%0b pc=%h pc8=%h instr=%h expected=v1 pc=00000000 pc8=00000008 instr=e3a00001",
               bus0.instr_valid_o, bus0.pc_o, bus0.pc_plus8_o, bus0.instr_o);
    end
    repeat (12) tick();
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
      failures++; $display("[TB] FAIL basic_req_addrs actual_count=%0d expected=00000000,00000004,00000008", acc_log.size());
    end
    checks++;
    if (dq0.size() < 6) begin failures++; $display("[TB] FAIL basic_delivered actual=%0d expected>=6", dq0.size()); end
    while (dq0.size() > 0) begin
      e = dq0.pop_front();
      checks++;
      if (e[63:32] !== exp_pc0 || e[31:0] !== word_of(exp_pc0)) begin
        failures++; $display("[TB] FAIL basic_order actual=%h/%h expected=%h/%h", e[63:32], e[31:0], exp_pc0, word_of(exp_pc0));
      end
      exp_pc0 += 32'd4;
    end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic [31:0] s_pc8;
    int          n;
    bus0.instr_ready_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus0.instr_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid actual=%0b expected=1", bus0.instr_valid_o); end
    s_instr = bus0.instr_o;
    s_pc    = bus0.pc_o;
    s_pc8   = bus0.pc_plus8_o;
    checks++;
    if (s_pc !== exp_pc0) begin failures++; $display("[TB] FAIL stall_head_pc actual=%h expected=%h", s_pc, exp_pc0); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus0.instr_o !== s_instr || bus0.pc_o !== s_pc || bus0.pc_plus8_o !== s_pc8) begin
        failures++; $display("[TB] FAIL stall_stable actual=%h/%h/%h expected=%h/%h/%h",
                             bus0.instr_o, bus0.pc_o, bus0.pc_plus8_o, s_instr, s_pc, s_pc8);
      end
    end
    checks++;
    if (dut0.u_fifo.count !== 2'd2) begin failures++; $display("[TB] FAIL stall_held actual=%0d expected=2", dut0.u_fifo.count); end
    checks++;
    if (bus0.imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_no_req actual=%0b expected=0", bus0.imem_req_o); end
    bus0.instr_ready_i = 1'b1;
    repeat (8) tick();
    n = dq0.size();
    checks++;
    if (n < 4) begin failures++; $display("[TB] FAIL stall_release_count actual=%0d expected>=4", n); end
    while (dq0.size() > 0) begin
      e = dq0.pop_front();
      checks++;
      if (e[63:32] !== exp_pc0 || e[31:0] !== word_of(exp_pc0)) begin
        failures++; $display("[TB] FAIL stall_order actual=%h/%h expected=%h/%h", e[63:32], e[31:0], exp_pc0, word_of(exp_pc0));
      end
      exp_pc0 += 32'd4;
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] first_pc;
    int          stale;
    bus0.imem_gnt_i = 1'b0;
    repeat (4) tick();
    while (dq0.size() > 0) begin
      e = dq0.pop_front();
      checks++;
      if (e[63:32] !== exp_pc0 || e[31:0] !== word_of(exp_pc0)) begin
        failures++; $display("[TB] FAIL redirect_drain actual=%h/%h expected=%h/%h", e[63:32], e[31:0], exp_pc0, word_of(exp_pc0));
      end
      exp_pc0 += 32'd4;
    end
    lat = 3;
    bus0.imem_gnt_i = 1'b1;
    addr_a = bus0.imem_addr_o;
    tick();
    addr_b = bus0.imem_addr_o;
    bus0.redirect_i        = 1'b1;
    bus0.redirect_target_i = 32'h0000_1002;
    tick();
    bus0.redirect_i = 1'b0;
    exp_pc0 = 32'h0000_1000;
    #1;
    checks++;
    if (bus0.imem_addr_o !== 32'h0000_1000) begin failures++; $display("[TB] FAIL redirect_addr actual=%h expected=00001000", bus0.imem_addr_o); end
    checks++;
    if (bus0.imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL redirect_credit actual=%0b expected=0", bus0.imem_req_o); end
    checks++;
    if (bus0.instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL redirect_flush actual=%0b expected=0", bus0.instr_valid_o); end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus0.instr_valid_o && (bus0.instr_o === word_of(addr_a) || bus0.instr_o === word_of(addr_b))) stale++;
    end
    checks++;
    if (stale !== 0) begin failures++; $display("[TB] FAIL redirect_stale actual=%0d expected=0", stale); end
    first_pc = (dq0.size() > 0) ? dq0[0][63:32] : 32'hFFFF_FFFF;
    checks++;
    if (first_pc !== 32'h0000_1000) begin failures++; $display("[TB] FAIL redirect_first_pc actual=%h expected=00001000", first_pc); end
    bus0.imem_gnt_i = 1'b0;
    repeat (6) tick();
    while (dq0.size() > 0) begin
      e = dq0.pop_front();
      checks++;
      if (e[63:32] !== exp_pc0 || e[31:0] !== word_of(exp_pc0)) begin
        failures++; $display("[TB] FAIL redirect_order actual=%h/%h expected=%h/%h", e[63:32], e[31:0], exp_pc0, word_of(exp_pc0));
      end
      exp_pc0 += 32'd4;
    end
    lat = 1;
  endtask

  task automatic test_gnt_low();
    logic [31:0] snap;
    snap = bus0.imem_addr_o;
    checks++;
    if (snap !== exp_pc0) begin failures++; $display("[TB] FAIL gnt_low_addr actual=%h expected=%h", snap, exp_pc0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus0.imem_req_o !== 1'b1 || bus0.imem_addr_o !== snap || bus0.instr_valid_o !== 1'b0) begin
        failures++; $display("[TB] FAIL gnt_low_hold actual=req%0b@%h v%0b expected=req1@%h v0",
                             bus0.imem_req_o, bus0.imem_addr_o, bus0.instr_valid_o, snap);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    logic [31:0] first_pc;
    bus0.imem_gnt_i    = 1'b1;
    bus0.instr_ready_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (dut0.u_fifo.count !== 2'd2) begin failures++; $display("[TB] FAIL rstmid_full actual=%0d expected=2", dut0.u_fifo.count); end
    rst0 = 1'b1;
    bus0.redirect_i        = 1'b1;
    bus0.redirect_target_i = 32'h0000_2000;
    bus0.instr_ready_i     = 1'b1;
    tick();
    checks++;
    if (bus0.imem_req_o !== 1'b0 || bus0.instr_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_ctrl actual=req%0b v%0b expected=req0 v0", bus0.imem_req_o, bus0.instr_valid_o);
    end
    checks++;
    if (bus0.instr_o !== 32'h0 || bus0.pc_o !== 32'h0 || bus0.pc_plus8_o !== 32'h8) begin
      failures++; $display("[TB] FAIL rstmid_data actual=%h/%h/%h expected=00000000/00000000/00000008",
                           bus0.instr_o, bus0.pc_o, bus0.pc_plus8_o);
    end
    rst0 = 1'b0;
    bus0.redirect_i = 1'b0;
    bus0.imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus0.instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_quiet actual=%0b expected=0", bus0.instr_valid_o); end
    end
    exp_pc0 = 32'h0;
    bus0.imem_gnt_i = 1'b1;
    repeat (8) tick();
    first_pc = (dq0.size() > 0) ? dq0[0][63:32] : 32'hFFFF_FFFF;
    checks++;
    if (first_pc !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_first_pc actual=%h expected=00000000", first_pc); end
    while (dq0.size() > 0) begin
      e = dq0.pop_front();
      checks++;
      if (e[63:32] !== exp_pc0 || e[31:0] !== word_of(exp_pc0)) begin
        failures++; $display("[TB] FAIL rstmid_order actual=%h/%h expected=%h/%h", e[63:32], e[31:0], exp_pc0, word_of(exp_pc0));
      end
      exp_pc0 += 32'd4;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcs [3];
    exp_pcs[0] = 32'hFFFF_FFF8;
    exp_pcs[1] = 32'hFFFF_FFFC;
    exp_pcs[2] = 32'h0000_0000;
    rst1 = 1'b0;
    bus1.imem_gnt_i    = 1'b1;
    bus1.instr_ready_i = 1'b1;
    repeat (10) tick();
    checks++;
    if (dq1.size() < 3) begin failures++; $display("[TB] FAIL wrap_count actual=%0d expected>=3", dq1.size()); end
    for (int i = 0; i < 3; i++) begin
      if (dq1.size() > i) begin
        checks++;
        if (dq1[i][63:32] !== exp_pcs[i] || dq1[i][31:0] !== word_of(exp_pcs[i])) begin
          failures++; $display("[TB] FAIL wrap_pc%0d actual=%h/%h expected=%h/%h", i, dq1[i][63:32], dq1[i][31:0],
                               exp_pcs[i], word_of(exp_pcs[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_gnt_low();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage upstream of the immediate extender and decoder. It owns the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Fetched words are buffered in a small in-order FIFO and presented to decode with a valid/ready handshake, so decode can take instr[23:0] and the PC. Branch redirects from execute flush the buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding memory requests (power of 2, >=2)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch word address, bits[1:0] always 0
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid; responses return in request order
imem_rdata_i  input  32  instruction word
redirect_i  input  1  branch taken; flush and restart at target
redirect_target_i  input  32  new PC; bits[1:0] ignored (forced 0)
instr_valid_o  output  1  instruction available to decode
instr_ready_i  input  1  decode accepts the instruction
instr_o  output  32  instruction word; decode/extend use instr_o[23:0]
pc_o  output  32  address of instr_o
pc_plus8_o  output  32  pc_o + 8 (ARM PC-read value, branch base)

Behaviour:
- Reset (rst_i high at an edge): fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop count = 0. Outputs read imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, pc_plus8_o=RESET_PC+8. Reset overrides redirect and any handshake in the same cycle.
- Credit rule: imem_req_o = !rst_i && (occupancy + outstanding < FIFO_DEPTH). imem_addr_o = fetch_pc.
- Request accepted on req&&gnt. fetch_pc += 4 and outstanding increments. Wrap-around from 32'hFFFF_FFFC goes to 0.
- Response on rvalid. If the drop count is > 0, the data is discarded and the drop count decrements. Otherwise {pc, word} is pushed into the FIFO, with pc taken from a response-PC counter that increments by 4 per accepted response. Outstanding decrements in either case.
- Same-cycle accept and response: outstanding stays unchanged.
- Decode handshake: the FIFO head is popped on instr_valid_o && instr_ready_i. instr_o, pc_o and pc_plus8_o hold stable while valid && !ready. instr_o holds its last value when the FIFO is empty.
- Push and pop in the same cycle are allowed when full. Overflow cannot occur because of the credit rule; the bench asserts this.
- Redirect (rst_i low, redirect_i high):
  - Next cycle: FIFO empty, fetch_pc = {target[31:2],2'b00}, response PC = the same value.
  - Drop count = outstanding after this cycle's accept/response.
  - Any accept in the redirect cycle still counts as in-flight and is therefore dropped.
  - A pop in the redirect cycle is honoured; the entry is gone afterwards either way.
  - A request may issue in the cycle after redirect if credits allow. Credits count in-flight dropped requests, so the cap still holds.
- Latency without bypass: rvalid at cycle N gives instr_valid_o at N+1. Steady-state throughput is one instruction per cycle with gnt=1, single-cycle memory and FIFO_DEPTH>=2.
- imem_rdata_i is ignored when rvalid is low.

Optional Feature:
- FETCH_BYPASS_EN defined: when the FIFO is empty, the drop count is 0 and rvalid is high, the response appears on instr_o/pc_o/instr_valid_o combinationally in the same cycle. If instr_ready_i is also high, the response is consumed without being written to the FIFO; otherwise it is pushed.
- Undefined: no combinational path from rvalid/rdata to outputs; latency is 1 cycle as above.

Decomposition:
- fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t; localparam PC_STEP = 4; localparam PC_READ_OFFSET = 8.
- Sub-module fetch_fifo, parameterised by depth and entry type, with push/pop/flush, full/empty and a count output. fetch_unit holds the PC, credit, drop and redirect logic.

Test Plan:
1. Reset, then gnt=1 with 1-cycle memory returning words 0xE3A0_0001.. and ready=1: requests at 0x0,0x4,0x8; instr_valid_o first at cycle 2 (no bypass) with pc_o=0, pc_plus8_o=8; one instruction per cycle afterwards.
2. ready=0 for 5 cycles: exactly FIFO_DEPTH instructions held, imem_req_o=0 once credits are exhausted, outputs stable; release ready -> in-order delivery with no loss.
3. Redirect to 0x0000_1002 while 2 requests are in flight: both responses dropped, next delivered pc_o=0x0000_1000, and no stale word appears on instr_o.
4. Wrap: RESET_PC=32'hFFFF_FFF8 -> delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
5. gnt held low for 3 cycles with req high: imem_addr_o stable; instr_valid_o stays 0.
6. rst_i asserted mid-stream with a full FIFO and a redirect in the same cycle: next cycle outputs at reset values and pc_o=RESET_PC; later responses to pre-reset requests are not presented.
